// File: rtl/awgn_ctrl_pkg.sv
// Shared types and constants for the AWGN core sequencer: FSM states,
// power-on Tausworthe seeds and the seed-reload hold time.
package awgn_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_WARMUP = 3'd2,
      ST_RUN    = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   localparam logic [31:0] SEED_S1_DEF = 32'hFFFF_FFFF;
   localparam logic [31:0] SEED_S2_DEF = 32'hFDFD_FDFD;
   localparam logic [31:0] SEED_S3_DEF = 32'hEFEF_EFEF;
   localparam logic [31:0] SEED_S4_DEF = 32'hFEDA_FEDA;
   localparam logic [31:0] SEED_S5_DEF = 32'hFFFA_FFFA;
   localparam logic [31:0] SEED_S6_DEF = 32'hFDEA_FDEA;

   localparam int LOAD_CYC = 2;

   function automatic logic [31:0] seed_default(input logic [2:0] idx);
      case (idx)
         3'd0:    return SEED_S1_DEF;
         3'd1:    return SEED_S2_DEF;
         3'd2:    return SEED_S3_DEF;
         3'd3:    return SEED_S4_DEF;
         3'd4:    return SEED_S5_DEF;
         3'd5:    return SEED_S6_DEF;
         default: return 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/awgn_sample_fifo.sv
// First-word fall-through sample-pair FIFO; a pop in the same cycle frees a
// slot so a full FIFO can still accept a push.
module awgn_sample_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [W-1:0]               i_data,
   input  logic                       i_pop,
   output logic [W-1:0]               o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_pop;
   logic          w_do_push;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/awgn_seq_ctrl.sv
// Sequencer for the Box-Muller AWGN core: seeds, core reset, warm-up and
// burst capture into a sample-pair FIFO.
//   state  | meaning
//   IDLE   | core held in reset, seeds writable, waiting for start
//   LOAD   | core held in reset so it reloads the seeds
//   WARMUP | core running, outputs discarded while its pipeline fills
//   RUN    | one pair per cycle pushed (or dropped when full)
//   DRAIN  | core back in reset, waiting for consumer to empty the FIFO
//   DONE   | one-cycle completion pulse
module awgn_seq_ctrl
   import awgn_ctrl_pkg::*;
#(
   parameter int SW         = 16,
   parameter int WARMUP_CYC = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_seed_we,
   input  logic [2:0]       i_seed_idx,
   input  logic [31:0]      i_seed_in,
   input  logic [LEN_W-1:0] i_burst_len,
   input  logic             i_start,
   output logic             o_core_rst,
   output logic [31:0]      o_s1,
   output logic [31:0]      o_s2,
   output logic [31:0]      o_s3,
   output logic [31:0]      o_s4,
   output logic [31:0]      o_s5,
   output logic [31:0]      o_s6,
   input  logic [SW-1:0]    i_core_x0,
   input  logic [SW-1:0]    i_core_x1,
   output logic [2*SW-1:0]  o_out_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_overflow,
   output logic [LEN_W-1:0] o_drop_cnt
);

   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int TMR_MAX = (WARMUP_CYC > LOAD_CYC) ? WARMUP_CYC : LOAD_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   state_t           r_state;
   logic             r_core_rst;
   logic [TMR_W-1:0] r_tmr;
   logic [LEN_W-1:0] r_remain;
   logic             r_overflow;
   logic [LEN_W-1:0] r_drop_cnt;
   logic [31:0]      r_seed [6];

   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   assign w_pop  = !w_empty && i_out_ready;
   assign w_push = (r_state == ST_RUN) && (!w_full || w_pop);
   assign w_drop = (r_state == ST_RUN) && w_full && !w_pop;

   awgn_sample_fifo #(
      .W     (2*SW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_data  ({i_core_x1, i_core_x0}),
      .i_pop   (w_pop),
      .o_data  (o_out_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_core_rst <= 1'b1;
         r_tmr      <= '0;
         r_remain   <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
         for (int i = 0; i < 6; i++) r_seed[i] <= seed_default(3'(i));
      end else begin
         if (r_state == ST_IDLE && i_seed_we && i_seed_idx <= 3'd5)
            r_seed[i_seed_idx] <= i_seed_in;
         case (r_state)
            ST_IDLE: begin
               r_core_rst <= 1'b1;
               if (i_start) begin
                  if (i_burst_len != '0) begin
                     r_remain   <= i_burst_len;
                     r_overflow <= 1'b0;
                     r_drop_cnt <= '0;
                     r_tmr      <= TMR_W'(LOAD_CYC - 1);
                     r_state    <= ST_LOAD;
                  end else begin
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_LOAD: begin
               if (r_tmr == '0) begin
                  r_tmr      <= TMR_W'(WARMUP_CYC - 1);
                  r_core_rst <= 1'b0;
                  r_state    <= ST_WARMUP;
               end else begin
                  r_tmr <= r_tmr - 1'b1;
               end
            end
            ST_WARMUP: begin
               if (r_tmr == '0) r_state <= ST_RUN;
               else             r_tmr   <= r_tmr - 1'b1;
            end
            ST_RUN: begin
               if (w_push) begin
                  r_remain <= r_remain - 1'b1;
                  if (r_remain == LEN_W'(1)) begin
                     r_core_rst <= 1'b1;
                     r_state    <= ST_DRAIN;
                  end
               end
               if (w_drop) begin
                  r_overflow <= 1'b1;
                  if (r_drop_cnt != {LEN_W{1'b1}}) r_drop_cnt <= r_drop_cnt + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (w_count == '0) r_state <= ST_DONE;
            end
            ST_DONE:  r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_core_rst  = r_core_rst;
   assign o_out_valid = !w_empty;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_done      = (r_state == ST_DONE);
   assign o_overflow  = r_overflow;
   assign o_drop_cnt  = r_drop_cnt;
   assign o_s1 = r_seed[0];
   assign o_s2 = r_seed[1];
   assign o_s3 = r_seed[2];
   assign o_s4 = r_seed[3];
   assign o_s5 = r_seed[4];
   assign o_s6 = r_seed[5];

endmodule

// File: tb/tb_awgn_seq_ctrl.sv
// Scoreboard bench for awgn_seq_ctrl: a cycle-count reference model predicts
// captured pairs, core reset and valid; a monitor checks every transfer.
module tb_awgn_seq_ctrl;

   localparam int SW = 16, WARM = 4, DEPTH = 8, LEN_W = 16;

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             seed_we = 1'b0;
   logic [2:0]       seed_idx = '0;
   logic [31:0]      seed_in = '0;
   logic [LEN_W-1:0] burst_len = '0;
   logic             start = 1'b0;
   logic             core_rst;
   logic [31:0]      s1, s2, s3, s4, s5, s6;
   logic [SW-1:0]    core_x0 = '0, core_x1 = '0;
   logic [2*SW-1:0]  out_data;
   logic             out_valid, out_ready = 1'b0;
   logic             busy, done, overflow;
   logic [LEN_W-1:0] drop_cnt;

   awgn_seq_ctrl #(.SW(SW), .WARMUP_CYC(WARM), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_seed_we(seed_we), .i_seed_idx(seed_idx),
      .i_seed_in(seed_in), .i_burst_len(burst_len), .i_start(start),
      .o_core_rst(core_rst), .o_s1(s1), .o_s2(s2), .o_s3(s3), .o_s4(s4), .o_s5(s5), .o_s6(s6),
      .i_core_x0(core_x0), .i_core_x1(core_x1), .o_out_data(out_data),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_busy(busy), .o_done(done),
      .o_overflow(overflow), .o_drop_cnt(drop_cnt));

   always #10 clk = ~clk;

   int checks = 0, failures = 0;
   int n_done = 0, n_xfer = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // reference model state
   logic [31:0] sb[$];
   int  m_occ = 0, m_k = 0, m_cap = 0, m_len = 0, m_drops = 0;
   bit  m_active = 1'b0;

   initial forever begin
      core_x0 = SW'($urandom);
      core_x1 = SW'($urandom);
      @(posedge clk);
      #1;
   end

   // Model: burst timeline measured in edges from the start edge t.
   // Pairs are captured at edges t+3+WARM onward until burst_len are kept.
   initial forever begin
      bit was_active, pop, push;
      @(negedge clk);
      if (!rst_n) begin
         sb.delete();
         m_occ = 0; m_active = 1'b0; m_cap = 0; m_len = 0; m_k = 0;
      end else begin
         was_active = m_active;
         pop  = (m_occ > 0) && out_ready;
         push = 1'b0;
         chk("core_rst", 64'(core_rst), 64'(!(was_active && m_k >= 3 && m_cap < m_len)));
         chk("out_valid", 64'(out_valid), 64'(m_occ > 0));
         if (was_active && m_k >= 3 + WARM && m_cap < m_len) begin
            if (m_occ < DEPTH || pop) begin
               sb.push_back({core_x1, core_x0});
               m_cap++;
               push = 1'b1;
            end else begin
               m_drops++;
            end
         end
         m_occ = m_occ + int'(push) - int'(pop);
         if (was_active) begin
            m_k++;
            if (m_cap == m_len) m_active = 1'b0;
         end else if (start && burst_len != 0) begin
            m_active = 1'b1; m_k = 1; m_cap = 0; m_len = int'(burst_len); m_drops = 0;
         end
      end
   end

   // Monitor
   initial forever begin
      logic [31:0] exp;
      @(negedge clk);
      if (rst_n) begin
         if (done) n_done++;
         if (out_valid && out_ready) begin
            n_xfer++;
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_transfer actual=%0h required=none", out_data);
            end else begin
               exp = sb.pop_front();
               chk("out_data", 64'(out_data), 64'(exp));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int len);
      burst_len = LEN_W'(len);
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic write_seed(input logic [2:0] idx, input logic [31:0] val);
      seed_idx = idx; seed_in = val; seed_we = 1'b1;
      tick(1);
      seed_we = 1'b0;
   endtask

   // pct: probability (percent) of out_ready per cycle while waiting
   task automatic wait_idle(input string name, input int budget, input int pct);
      int c = 0;
      while (busy && c < budget) begin
         out_ready = ($urandom_range(0, 99) < pct);
         tick(1);
         c++;
      end
      chk({name, "_idle"}, 64'(busy), 64'd0);
      out_ready = 1'b1;
      tick(2);
   endtask

   task automatic check_burst(input string name, input int len);
      chk({name, "_done_cnt"}, 64'(n_done), 64'd1);
      chk({name, "_xfers"}, 64'(n_xfer), 64'(len));
      chk({name, "_overflow"}, 64'(overflow), 64'(m_drops > 0));
      chk({name, "_drop_cnt"}, 64'(drop_cnt), 64'(m_drops));
      n_done = 0; n_xfer = 0;
   endtask

   task automatic check_defaults(input string name, input logic [31:0] e3);
      chk({name, "_s1"}, 64'(s1), 64'h FFFF_FFFF);
      chk({name, "_s2"}, 64'(s2), 64'h FDFD_FDFD);
      chk({name, "_s3"}, 64'(s3), 64'(e3));
      chk({name, "_s4"}, 64'(s4), 64'h FEDA_FEDA);
      chk({name, "_s5"}, 64'(s5), 64'h FFFA_FFFA);
      chk({name, "_s6"}, 64'(s6), 64'h FDEA_FDEA);
   endtask

   initial begin
      int len, pct;
      #25;
      check_defaults("rst", 32'hEFEF_EFEF);
      chk("rst_core_rst", 64'(core_rst), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      @(posedge clk); #3; rst_n = 1'b1;
      tick(2);

      write_seed(3'd2, 32'h1234_5678);
      chk("seed_s3_write", 64'(s3), 64'h1234_5678);
      write_seed(3'd7, 32'hDEAD_BEEF);
      check_defaults("seed_idx7", 32'h1234_5678);

      out_ready = 1'b1;
      n_done = 0; n_xfer = 0;
      do_start(10);
      wait_idle("nominal", 200, 100);
      check_burst("nominal", 10);

      out_ready = 1'b0;
      do_start(20);
      tick(12);
      write_seed(3'd2, 32'hAAAA_5555);
      chk("seed_busy_s3", 64'(s3), 64'h1234_5678);
      do_start(3);
      tick(10);
      chk("bp_overflow_mid", 64'(overflow), 64'd1);
      chk("bp_valid_full", 64'(out_valid), 64'd1);
      wait_idle("backpressure", 300, 100);
      check_burst("backpressure", 20);

      do_start(0);
      tick(3);
      chk("zero_done_cnt", 64'(n_done), 64'd1);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_xfers", 64'(n_xfer), 64'd0);
      n_done = 0; n_xfer = 0;

      for (int i = 0; i < 6; i++) begin
         len = $urandom_range(1, 24);
         pct = $urandom_range(15, 100);
         out_ready = ($urandom_range(0, 99) < pct);
         do_start(len);
         wait_idle("random", 600, pct);
         check_burst("random", len);
      end

      out_ready = 1'b1;
      do_start(15);
      tick(9);
      #3;
      rst_n = 1'b0;
      #1;
      check_defaults("midrst", 32'hEFEF_EFEF);
      chk("midrst_core_rst", 64'(core_rst), 64'd1);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
      @(posedge clk); #5; rst_n = 1'b1;
      tick(2);
      n_done = 0; n_xfer = 0;
      do_start(5);
      wait_idle("post_reset", 200, 100);
      check_burst("post_reset", 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/awgn_seq_ctrl.md
Name: awgn_seq_ctrl

Overview:
Sequencer for the Box-Muller AWGN core (`Main`).
- Owns the six Tausworthe seeds and drives the core's active-high reset.
- On start: loads seeds, holds the core in reset, waits out pipeline warm-up, then captures a programmed burst of {x1,x0} sample pairs.
- Captured pairs go into a small FIFO that feeds a valid/ready consumer.
- The core cannot stall, so pairs arriving when the FIFO is full are dropped and flagged.

Parameters:
- SW, 16: sample width of core x0/x1.
- WARMUP_CYC, 4: core cycles discarded after core reset release (pipeline fill).
- FIFO_DEPTH, 8: sample-pair FIFO depth; power of 2, minimum 2.
- LEN_W, 16: burst length counter width.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- seed_we  in  1  seed write strobe.
- seed_idx  in  3  seed select, 0..5 maps to s1..s6; 6 and 7 are ignored.
- seed_in  in  32  seed write data.
- burst_len  in  LEN_W  number of pairs to capture; sampled on start.
- start  in  1  single-cycle start request.
- core_rst  out  1  active-high reset to the AWGN core.
- s1..s6  out  32 each  seed buses to the core.
- core_x0, core_x1  in  SW each  core outputs, new pair every cycle.
- out_data  out  2*SW  {x1,x0} head of FIFO.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accept; transfer when valid&&ready.
- busy  out  1  state != IDLE.
- done  out  1  single-cycle pulse at burst completion.
- overflow  out  1  sticky: at least one pair dropped this burst.
- drop_cnt  out  LEN_W  pairs dropped this burst, saturating.

Behaviour:
- Reset (reset=0) values:
  - state IDLE; core_rst=1; FIFO empty; out_valid=0; out_data=0.
  - busy=0, done=0, overflow=0, drop_cnt=0.
  - Seeds: s1=FFFFFFFF, s2=FDFDFDFD, s3=EFEFEFEF, s4=FEDAFEDA, s5=FFFAFFFA, s6=FDEAFDEA.
- Seed writes:
  - Accepted only in IDLE; the selected register updates at the next edge.
  - Ignored when busy or when seed_idx>5.
- FSM states: IDLE, LOAD, WARMUP, RUN, DRAIN, DONE.
- IDLE:
  - core_rst=1.
  - start && burst_len!=0: latch burst_len, clear overflow and drop_cnt, go to LOAD.
  - start && burst_len==0: go to DONE; the core is never released.
  - start while busy is ignored.
- LOAD:
  - 2 cycles with core_rst=1, so the core reloads the seeds; then go to WARMUP.
- WARMUP:
  - core_rst=0 for WARMUP_CYC cycles; core outputs are discarded; then go to RUN.
- RUN:
  - Every cycle one pair {core_x1,core_x0} is presented to the FIFO.
  - FIFO not full: the pair is pushed and the capture counter increments.
  - FIFO full: the pair is dropped, overflow=1, drop_cnt increments (saturates at all-ones).
  - A pop in the same cycle frees space first, so a full FIFO with out_ready=1 accepts the push.
  - When the capture counter reaches the latched burst_len: core_rst=1, go to DRAIN.
  - Dropped pairs do not count toward burst_len.
- DRAIN:
  - core_rst=1; wait until the FIFO is empty, then go to DONE.
- DONE:
  - done=1 for one cycle, then go to IDLE.
  - overflow and drop_cnt hold until the next accepted start.
- Latency:
  - start sampled at edge t, so LOAD covers cycles t+1..t+2.
  - WARMUP covers t+3..t+2+WARMUP_CYC.
  - First push happens at edge t+3+WARMUP_CYC; out_valid rises the following cycle.
- FIFO:
  - Registered output, first-word fall-through.
  - Simultaneous push and pop keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: returns everything to reset values immediately (asynchronous); FIFO contents are lost.

Decomposition:
- awgn_ctrl_pkg holds:
  - state enum;
  - the six default seed constants;
  - LOAD_CYC=2.
- One sub-module, awgn_sample_fifo: parameterized width 2*SW and depth FIFO_DEPTH; outputs full, empty, count.

Test Plan:
- Reset defaults: assert reset=0 mid-run → s1..s6 return to the default seeds, core_rst=1, out_valid=0, busy=0 with no clock edge.
- Seed write: seed_idx=2, seed_in=12345678 in IDLE → s3=12345678. Repeat while busy → s3 unchanged. seed_idx=7 → no seed changes.
- Nominal burst: burst_len=10, out_ready=1, WARMUP_CYC=4, start at edge t:
  - first push at t+7;
  - exactly 10 transfers, each matching the core's x0/x1 at capture;
  - done pulses once;
  - overflow=0.
- Backpressure: burst_len=20, out_ready=0 throughout RUN:
  - FIFO fills to 8; overflow=1;
  - 20 pairs captured in total once ready=1 is restored during RUN;
  - drop_cnt equals the number of cycles spent full.
- Zero length: start with burst_len=0 → done pulses 2 cycles later, core_rst stays 1, no out_valid.
- Start ignored when busy: second start during RUN has no effect; exactly one done pulse.
